lvds_tx: RTL and testbench
==========================

Name: lvds_tx

Overview:
- Transmit-side counterpart of the LVDS receive path: the EU fills a 32x512 word buffer, then issues START.
- The block serialises the frame onto LVDS_VS / LVDS_CLK / LVDS_DATA. Framing is the same as the receiver expects: VS high for the whole frame, MSB-first, receiver samples on LVDS_CLK rising edge.
- Status is reported to the EU through an 8-bit state register with chip-select-qualified clear, mirroring the receive side.

Parameters:
CLK_DIV, 2, LVDS_CLK half-period in CLK cycles (legal 1..255); one bit = 2*CLK_DIV CLK cycles
ADDR_W, 9, buffer address width
DEPTH, 512, buffer depth in 32-bit words (= 2**ADDR_W)

Ports:
CLK  in  1  system clock; all logic on rising edge; the block's single clock
RSTn  in  1  asynchronous active-low reset
EU_LVDS_TX_WDATA  in  32  buffer write data
EU_LVDS_TX_WADDR  in  ADDR_W  buffer write address
EU_LVDS_TX_WEN  in  1  buffer write enable, active high, one word per CLK
EU_LVDS_TX_LEN  in  ADDR_W+1  frame length in words, sampled with START
EU_LVDS_TX_START  in  1  one-cycle start pulse
LVDS_TX_STATE_CLEAR_CS  in  1  clear qualifier
LVDS_TX_STATE_CLEAR  in  1  clears sticky bits when CS also high
LVDS_VS  out  1  frame valid
LVDS_CLK  out  1  forwarded bit clock, idle low
LVDS_DATA  out  1  serial data
LVDS_TX_EU_STATE  out  8  [0] busy (live), [1] done (sticky), [2] error (sticky), [7:3] = 0

Behaviour:
- Reset:
  - All outputs are 0; FSM goes to IDLE; word and bit counters are 0.
  - Buffer contents are not reset.
  - Reset mid-frame drops VS/CLK/DATA to 0 immediately (asynchronous).
- Buffer:
  - Internal 32xDEPTH simple dual-port RAM on CLK.
  - EU write port has priority-free access, including while busy.
  - Internal synchronous read has 1-cycle latency.
  - Same-address read and write in the same cycle returns the old data.
- FSM states: IDLE, FETCH, SHIFT, DONE (one-hot).
- IDLE:
  - On START with 1 <= LEN <= DEPTH: latch LEN, set busy, read addr 0, go to FETCH.
  - LEN = 0 or LEN > DEPTH: no frame is sent, error bit is set, FSM stays in IDLE.
- FETCH (1 cycle):
  - Load the shift register from RAM output.
  - Issue a prefetch read of addr 1 (if LEN > 1).
  - Go to SHIFT.
  - LVDS_VS and the first bit (word0[31]) are registered outputs, first high/valid 2 CLK cycles after the START edge.
- SHIFT:
  - VS = 1.
  - Each bit period: LVDS_CLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - DATA changes only at the start of a bit period (LVDS_CLK falling), so it is stable around the rising edge.
  - After bit 0 of a word, the prefetched word loads with no gap, and the next address is prefetched.
  - After bit 0 of word LEN-1 completes, go to DONE.
  - VS is high for exactly LEN*32*2*CLK_DIV cycles.
- DONE (1 cycle):
  - VS = 0, CLK = 0, DATA = 0.
  - Set done bit, clear busy, return to IDLE.
  - A START in the DONE cycle is treated as busy.
- START while busy (FETCH/SHIFT/DONE): ignored, error bit set, frame in progress unaffected.
- State clear:
  - CLEAR_CS & CLEAR clears bits [1] and [2] next edge.
  - If a set event coincides with a clear, set wins.
  - Busy bit is not affected by clear.
- EU overwriting a word not yet fetched during a frame transmits the new data. Write-ordering is the EU's responsibility.

Test Plan:
- Reset, CLK_DIV=2: write 0xA5A5_0001 to addr 0, START with LEN=1 -> VS high 2 cycles after START for 128 cycles; DATA = 1,0,1,0,0,1,0,1,...,0,0,0,1 sampled at 32 LVDS_CLK rises; then state = 0x02.
- LEN=512, incrementing data -> 16384 continuous bits, no LVDS_CLK gaps at word boundaries; VS high exactly 65536 cycles; busy high throughout.
- START pulse mid-frame, then START with LEN=0 in IDLE -> frame unaffected, bit[2] set; CLEAR_CS&CLEAR -> state 0x00; CLEAR without CS -> no change.
- Done-set and clear in the same cycle -> bit[1] remains 1.
- Assert RSTn low mid-word -> VS/CLK/DATA 0 immediately; after release, new START with LEN=2 transmits correct data from word 0.
- CLK_DIV=1 build, LEN=3 -> LVDS_CLK toggles every CLK cycle; VS high 192 cycles; DATA matches buffer MSB-first.

Source files
------------

// File: rtl/lvds_tx_if.sv
// EU-side bus of the LVDS transmitter: buffer write port, frame start and the
// status register with its chip-select-qualified clear.
interface lvds_tx_if #(
    parameter int ADDR_W = 9
);
    logic [31:0]     EU_LVDS_TX_WDATA;
    logic [ADDR_W-1:0] EU_LVDS_TX_WADDR;
    logic            EU_LVDS_TX_WEN;
    logic [ADDR_W:0] EU_LVDS_TX_LEN;
    logic            EU_LVDS_TX_START;
    logic            LVDS_TX_STATE_CLEAR_CS;
    logic            LVDS_TX_STATE_CLEAR;
    logic [7:0]      LVDS_TX_EU_STATE;

    modport master (
        output EU_LVDS_TX_WDATA,
        output EU_LVDS_TX_WADDR,
        output EU_LVDS_TX_WEN,
        output EU_LVDS_TX_LEN,
        output EU_LVDS_TX_START,
        output LVDS_TX_STATE_CLEAR_CS,
        output LVDS_TX_STATE_CLEAR,
        input  LVDS_TX_EU_STATE
    );

    modport slave (
        input  EU_LVDS_TX_WDATA,
        input  EU_LVDS_TX_WADDR,
        input  EU_LVDS_TX_WEN,
        input  EU_LVDS_TX_LEN,
        input  EU_LVDS_TX_START,
        input  LVDS_TX_STATE_CLEAR_CS,
        input  LVDS_TX_STATE_CLEAR,
        output LVDS_TX_EU_STATE
    );
endinterface

// File: rtl/lvds_tx.sv
// LVDS frame transmitter: serialises LEN words from an EU-filled buffer onto
// VS/CLK/DATA, MSB-first, with data stable around each forwarded clock rise.
module lvds_tx #(
    parameter int CLK_DIV = 2,
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 512
) (
    input  logic     CLK,
    input  logic     RSTn,
    lvds_tx_if.slave eu,
    output logic     LVDS_VS,
    output logic     LVDS_CLK,
    output logic     LVDS_DATA
);

    localparam int                DIV_W    = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   LEN_TWO  = (ADDR_W + 1)'(2);
    localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        FETCH = 4'b0010,
        SHIFT = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [4:0]        bit_q, bit_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [31:0]       shift_q, shift_d;
    logic              vs_q, vs_d;
    logic              lclk_q, lclk_d;

    logic              done_set;
    logic              err_set;
    logic              clr;
    logic              start;
    logic              len_ok;
    logic              last_word;
    logic [ADDR_W:0]   pf_idx;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data_q;

    logic [31:0]       mem [DEPTH];

    // Buffer: EU write port and internal read port, read-before-write on a
    // shared address; contents survive reset.
    always_ff @(posedge CLK) begin
        if (eu.EU_LVDS_TX_WEN) begin
            mem[eu.EU_LVDS_TX_WADDR] <= eu.EU_LVDS_TX_WDATA;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign start     = eu.EU_LVDS_TX_START;
    assign clr       = eu.LVDS_TX_STATE_CLEAR_CS & eu.LVDS_TX_STATE_CLEAR;
    assign len_ok    = (eu.EU_LVDS_TX_LEN != '0) && (eu.EU_LVDS_TX_LEN <= LEN_MAX);
    assign last_word = ({1'b0, word_q} == (len_q - LEN_ONE));
    assign pf_idx    = {1'b0, word_q} + LEN_TWO;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        len_d    = len_q;
        word_d   = word_q;
        bit_d    = bit_q;
        div_d    = div_q;
        shift_d  = shift_q;
        vs_d     = vs_q;
        lclk_d   = lclk_q;
        done_set = 1'b0;
        err_set  = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = eu.EU_LVDS_TX_LEN;
                        busy_d  = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        state_d = FETCH;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end

            FETCH: begin
                shift_d = rd_data_q;
                vs_d    = 1'b1;
                lclk_d  = 1'b0;
                div_d   = '0;
                bit_d   = 5'd31;
                word_d  = '0;
                if (len_q > LEN_ONE) begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(1);
                end
                state_d = SHIFT;
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    lclk_d = 1'b0;
                    if (bit_q == 5'd0) begin
                        if (last_word) begin
                            vs_d    = 1'b0;
                            shift_d = '0;
                            state_d = DONE;
                        end else begin
                            // Prefetched word goes straight in; next one is requested now.
                            shift_d = rd_data_q;
                            word_d  = word_q + ADDR_W'(1);
                            bit_d   = 5'd31;
                            if (pf_idx < len_q) begin
                                rd_en   = 1'b1;
                                rd_addr = pf_idx[ADDR_W-1:0];
                            end
                        end
                    end else begin
                        shift_d = {shift_q[30:0], 1'b0};
                        bit_d   = bit_q - 5'd1;
                    end
                end else begin
                    div_d  = div_q + DIV_W'(1);
                    lclk_d = (div_d >= DIV_HALF);
                end
            end

            DONE: begin
                busy_d   = 1'b0;
                done_set = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (start && (state_q != IDLE)) begin
            err_set = 1'b1;
        end
    end

    // Sticky status: a set event in the same cycle as a clear wins.
    assign done_d = done_set | (done_q & ~clr);
    assign err_d  = err_set  | (err_q  & ~clr);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            shift_q <= '0;
            vs_q    <= 1'b0;
            lclk_q  <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            len_q   <= len_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            shift_q <= shift_d;
            vs_q    <= vs_d;
            lclk_q  <= lclk_d;
        end
    end

    assign LVDS_VS             = vs_q;
    assign LVDS_CLK            = lclk_q;
    assign LVDS_DATA           = shift_q[31];
    assign eu.LVDS_TX_EU_STATE = {5'b0, err_q, done_q, busy_q};

endmodule

// File: tb/tb_lvds_tx.sv
// Bench for lvds_tx: one instance with CLK_DIV=2 and one with CLK_DIV=1,
// checked against a bit-stream and sticky-status model.
module tb_lvds_tx;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic clk;
    logic rst_n;

    logic [31:0]       wdata [2];
    logic [ADDR_W-1:0] waddr [2];
    logic [ADDR_W:0]   len_i [2];
    logic [1:0]        wen;
    logic [1:0]        start;
    logic [1:0]        clr_cs;
    logic [1:0]        clr;
    logic [7:0]        st_o [2];
    logic [1:0]        vs_o;
    logic [1:0]        lclk_o;
    logic [1:0]        data_o;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lvds_tx_if #(.ADDR_W(ADDR_W)) bus ();
        assign bus.EU_LVDS_TX_WDATA       = wdata[g];
        assign bus.EU_LVDS_TX_WADDR       = waddr[g];
        assign bus.EU_LVDS_TX_WEN         = wen[g];
        assign bus.EU_LVDS_TX_LEN         = len_i[g];
        assign bus.EU_LVDS_TX_START       = start[g];
        assign bus.LVDS_TX_STATE_CLEAR_CS = clr_cs[g];
        assign bus.LVDS_TX_STATE_CLEAR    = clr[g];
        assign st_o[g]                    = bus.LVDS_TX_EU_STATE;

        lvds_tx #(.CLK_DIV((g == 0) ? 2 : 1), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dut (
            .CLK       (clk),
            .RSTn      (rst_n),
            .eu        (bus.slave),
            .LVDS_VS   (vs_o[g]),
            .LVDS_CLK  (lclk_o[g]),
            .LVDS_DATA (data_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: buffer image and sticky bits per instance.
    logic [31:0] mem_m [2][DEPTH];
    logic        done_m [2];
    logic        err_m [2];

    // Line monitor state.
    logic cap [2][16384];
    int   cap_n [2];
    int   vs_cyc [2];
    int   busy_bad [2];
    int   gap_bad [2];
    int   idle_bad [2];
    int   last_rise [2];
    bit   have_rise [2];
    logic lclk_prev [2];
    int   cyc = 0;

    function automatic int div_of(input int idx);
        return (idx == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_state(input int idx);
        return {5'b0, err_m[idx], done_m[idx], 1'b0};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (vs_o[i]) begin
                vs_cyc[i]++;
                if (!st_o[i][0]) busy_bad[i]++;
                if (lclk_o[i] && !lclk_prev[i]) begin
                    if (cap_n[i] < 16384) cap[i][cap_n[i]] = data_o[i];
                    cap_n[i]++;
                    if (have_rise[i] && ((cyc - last_rise[i]) != 2 * div_of(i))) gap_bad[i]++;
                    have_rise[i] = 1'b1;
                    last_rise[i] = cyc;
                end
            end else begin
                have_rise[i] = 1'b0;
                if (lclk_o[i] || data_o[i]) idle_bad[i]++;
            end
            lclk_prev[i] = lclk_o[i];
        end
        cyc++;
    end

    // All tasks enter and leave 1 time unit after a rising edge.
    task automatic wr(input int idx, input int a, input logic [31:0] d);
        wen[idx]   = 1'b1;
        waddr[idx] = ADDR_W'(a);
        wdata[idx] = d;
        @(posedge clk); #1;
        wen[idx] = 1'b0;
        mem_m[idx][a] = d;
    endtask

    task automatic run_frame(input int idx, input int len, input bit clr_at_done);
        int lim;
        int nbad;
        logic [31:0] w;
        cap_n[idx] = 0; vs_cyc[idx] = 0; busy_bad[idx] = 0; gap_bad[idx] = 0; idle_bad[idx] = 0;
        start[idx] = 1'b1;
        len_i[idx] = (ADDR_W + 1)'(len);
        @(posedge clk); #1;
        start[idx] = 1'b0;
        check("vs_lat1", vs_o[idx], 0);
        @(posedge clk); #1;
        check("vs_lat2", vs_o[idx], 1);
        lim = len * 64 * div_of(idx) + 10;
        while (vs_o[idx] && lim > 0) begin
            @(posedge clk); #1;
            lim--;
        end
        check("vs_fall_in_time", (lim > 0), 1);
        check("busy_in_done", st_o[idx][0], 1);
        if (clr_at_done) begin
            clr_cs[idx] = 1'b1;
            clr[idx]    = 1'b1;
        end
        @(posedge clk); #1;
        clr_cs[idx] = 1'b0;
        clr[idx]    = 1'b0;
        done_m[idx] = 1'b1;
        if (clr_at_done) err_m[idx] = 1'b0;
        check("state_after", st_o[idx], exp_state(idx));
        check("vs_cycles", vs_cyc[idx], len * 64 * div_of(idx));
        check("bit_count", cap_n[idx], len * 32);
        nbad = 0;
        for (int k = 0; k < len * 32 && k < 16384; k++) begin
            w = mem_m[idx][k / 32];
            if (cap[idx][k] !== w[31 - (k % 32)]) nbad++;
        end
        check("bit_errors", nbad, 0);
        check("clk_gaps", gap_bad[idx], 0);
        check("busy_drop", busy_bad[idx], 0);
        check("idle_lines", idle_bad[idx], 0);
    endtask

    task automatic start_bad(input int idx, input int len);
        start[idx] = 1'b1;
        len_i[idx] = (ADDR_W + 1)'(len);
        @(posedge clk); #1;
        start[idx] = 1'b0;
        err_m[idx] = 1'b1;
        check("err_state", st_o[idx], exp_state(idx));
        @(posedge clk); #1;
        check("no_frame", vs_o[idx], 0);
    endtask

    task automatic clear_st(input int idx, input bit cs, input bit c);
        clr_cs[idx] = cs;
        clr[idx]    = c;
        @(posedge clk); #1;
        clr_cs[idx] = 1'b0;
        clr[idx]    = 1'b0;
        if (cs && c) begin
            done_m[idx] = 1'b0;
            err_m[idx]  = 1'b0;
        end
        check("clear_state", st_o[idx], exp_state(idx));
    endtask

    initial begin
        logic [31:0] pat;
        logic [31:0] base;
        int          idx;
        int          len;

        for (int i = 0; i < 2; i++) begin
            wdata[i] = '0; waddr[i] = '0; len_i[i] = '0;
            done_m[i] = 1'b0; err_m[i] = 1'b0;
            cap_n[i] = 0; vs_cyc[i] = 0; busy_bad[i] = 0; gap_bad[i] = 0; idle_bad[i] = 0;
            last_rise[i] = 0; have_rise[i] = 1'b0; lclk_prev[i] = 1'b0;
        end
        wen = '0; start = '0; clr_cs = '0; clr = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_lines", {vs_o[i], lclk_o[i], data_o[i]}, 0);
            check("rst_state", st_o[i], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single known word, bit order checked one by one.
        pat = 32'hA5A5_0001;
        wr(0, 0, pat);
        run_frame(0, 1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("w0_bit%0d", k), cap[0][k], pat[31 - k]);
        end
        clear_st(0, 1'b1, 1'b1);

        // Full-depth frame with a START pulse arriving mid-frame.
        base = $urandom;
        for (int a = 0; a < DEPTH; a++) wr(0, a, base + 32'(a));
        fork
            run_frame(0, DEPTH, 1'b0);
            begin
                repeat (3000) @(posedge clk);
                #1;
                start[0] = 1'b1;
                len_i[0] = (ADDR_W + 1)'($urandom_range(1, 8));
                @(posedge clk); #1;
                start[0] = 1'b0;
                err_m[0] = 1'b1;
            end
        join
        start_bad(0, 0);
        clear_st(0, 1'b0, 1'b1);
        clear_st(0, 1'b1, 1'b0);
        clear_st(0, 1'b1, 1'b1);

        // Done-set coinciding with a clear: done survives, error is cleared.
        start_bad(1, 0);
        wr(1, 0, $urandom);
        run_frame(1, 1, 1'b1);
        check("done_wins", st_o[1], 8'h02);

        // Asynchronous reset in the middle of a word.
        wr(0, 0, $urandom);
        wr(0, 1, $urandom);
        start[0] = 1'b1;
        len_i[0] = (ADDR_W + 1)'(2);
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("pre_rst_vs", vs_o[0], 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_lines", {vs_o[0], lclk_o[0], data_o[0]}, 0);
        done_m[0] = 1'b0; err_m[0] = 1'b0;
        done_m[1] = 1'b0; err_m[1] = 1'b0;
        check("async_rst_state", st_o[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 2, 1'b0);

        // Fastest forwarded clock, three words.
        for (int a = 0; a < 3; a++) wr(1, a, $urandom);
        run_frame(1, 3, 1'b0);

        // Random frames and out-of-range lengths on either instance.
        for (int it = 0; it < 8; it++) begin
            idx = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) begin
                start_bad(idx, $urandom_range(DEPTH + 1, 1023));
            end else begin
                len = $urandom_range(1, 6);
                for (int a = 0; a < len; a++) wr(idx, a, $urandom);
                run_frame(idx, len, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
